// File: rtl/rdma_pkg.sv
// Shared definitions for the wide AXI4 read-DMA engine: AXI field encodings,
// the controller state type and the byte-enable mask helper.
package rdma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_ADDR,
    S_INCR,
    S_WAIT,
    S_DONE
  } rdma_state_t;

  // Ones on byte lanes lo..hi-1; sized for the widest (16-byte) data bus.
  function automatic logic [15:0] keep_mask(input logic [4:0] lo, input logic [4:0] hi);
    logic [15:0] m;
    m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      m[i] = (5'(i) >= lo) && (5'(i) < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/rdma_burst_calc.sv
// Burst sizing for the read-DMA engine: beats = min(remain, MAX_BURST, beats
// left in the current 4 KB page), plus the address/remain step after issue.
module rdma_burst_calc
  import rdma_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned LENGTH_BITS  = 32,
  parameter int unsigned DATA_BITS    = 64,
  parameter int unsigned MAX_BURST    = 256
) (
  input  logic [ADDRESS_BITS-1:0] i_araddr,
  input  logic [LENGTH_BITS:0]    i_remain,
  input  logic [8:0]              i_beats,
  output logic [8:0]              o_beats,
  output logic [ADDRESS_BITS-1:0] o_next_araddr,
  output logic [LENGTH_BITS:0]    o_next_remain
);

  localparam int unsigned W = $clog2(DATA_BITS / 8);
  localparam logic [12:0] MB = 13'(MAX_BURST);

  logic [12:0]        w_page_bytes;
  logic [12:0]        w_page_beats;
  logic [12:0]        w_cap;
  logic [LENGTH_BITS:0] w_cap_ext;

  always_comb begin
    w_page_bytes = 13'd4096 - {1'b0, i_araddr[11:0]};
    w_page_beats = w_page_bytes >> W;
    w_cap        = (w_page_beats < MB) ? w_page_beats : MB;
    w_cap_ext    = {{(LENGTH_BITS - 12){1'b0}}, w_cap};
    o_beats      = (i_remain < w_cap_ext) ? i_remain[8:0] : w_cap[8:0];
  end

  assign o_next_araddr = i_araddr + ({{(ADDRESS_BITS - 9){1'b0}}, i_beats} << W);
  assign o_next_remain = i_remain - {{(LENGTH_BITS - 8){1'b0}}, i_beats};

endmodule

// File: rtl/axi_rdma_wide.sv
// AXI4 read-DMA engine: one byte-addressed command -> INCR bursts -> AXI-Stream.
// Optional RDMA_ERR_REPORT_EN enables the sticky cmd_error response flag.
module axi_rdma_wide
  import rdma_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned LENGTH_BITS  = 32,
  parameter int unsigned DATA_BITS    = 64,
  parameter int unsigned MAX_BURST    = 256,
  parameter int unsigned ID           = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDRESS_BITS-1:0]   cmd_address,
  input  logic [LENGTH_BITS-1:0]    cmd_bytes,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic                      cmd_done,
  output logic                      cmd_error,
  output logic [3:0]                axi_m_arid,
  output logic [ADDRESS_BITS-1:0]   axi_m_araddr,
  output logic [7:0]                axi_m_arlen,
  output logic [2:0]                axi_m_arsize,
  output logic [1:0]                axi_m_arburst,
  output logic                      axi_m_arvalid,
  input  logic                      axi_m_arready,
  input  logic [3:0]                axi_m_rid,
  input  logic [DATA_BITS-1:0]      axi_m_rdata,
  input  logic [1:0]                axi_m_rresp,
  input  logic                      axi_m_rlast,
  input  logic                      axi_m_rvalid,
  output logic                      axi_m_rready,
  output logic [DATA_BITS-1:0]      dout_tdata,
  output logic [DATA_BITS/8-1:0]    dout_tkeep,
  output logic                      dout_tlast,
  output logic                      dout_tvalid,
  input  logic                      dout_tready
);

  localparam int unsigned B  = DATA_BITS / 8;
  localparam int unsigned W  = $clog2(B);
  localparam int unsigned CW = LENGTH_BITS + 1;

  rdma_state_t r_state, w_next;

  logic [ADDRESS_BITS-1:0] r_addr;
  logic [LENGTH_BITS-1:0]  r_bytes;
  logic [ADDRESS_BITS-1:0] r_araddr;
  logic [CW-1:0]           r_remain;
  logic [CW-1:0]           r_total;
  logic [CW-1:0]           r_beat_cnt;
  logic [8:0]              r_beats;
  logic [B-1:0]            r_keep_first;
  logic [B-1:0]            r_keep_last;

  logic [W-1:0]            w_off;
  logic [W-1:0]            w_last_idx;
  logic [CW-1:0]           w_total;
  logic [15:0]             w_kf;
  logic [15:0]             w_kl;
  logic [8:0]              w_calc_beats;
  logic [ADDRESS_BITS-1:0] w_next_araddr;
  logic [CW-1:0]           w_next_remain;
  logic                    w_active;
  logic                    w_fire;
  logic                    w_first;
  logic                    w_last;
  logic [B-1:0]            w_keep;

  // Beat count is the byte span rounded up to whole bus words, offset included.
  assign w_off      = r_addr[W-1:0];
  assign w_total    = ({1'b0, r_bytes} + CW'(w_off) + CW'(B - 1)) >> W;
  assign w_last_idx = w_off + r_bytes[W-1:0] - W'(1);
  assign w_kf       = keep_mask(5'(w_off), 5'(B));
  assign w_kl       = keep_mask(5'd0, 5'(w_last_idx) + 5'd1);

  rdma_burst_calc #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .LENGTH_BITS  (LENGTH_BITS),
    .DATA_BITS    (DATA_BITS),
    .MAX_BURST    (MAX_BURST)
  ) u_burst_calc (
    .i_araddr      (r_araddr),
    .i_remain      (r_remain),
    .i_beats       (r_beats),
    .o_beats       (w_calc_beats),
    .o_next_araddr (w_next_araddr),
    .o_next_remain (w_next_remain)
  );

  assign w_active     = (r_state != S_IDLE);
  assign axi_m_rready = dout_tready & w_active;
  assign dout_tvalid  = axi_m_rvalid & w_active;
  assign dout_tdata   = axi_m_rdata;
  assign w_fire       = dout_tvalid & dout_tready;
  assign w_first      = (r_beat_cnt == '0);
  assign w_last       = (r_beat_cnt == r_total - CW'(1));
  assign dout_tlast   = w_last;

  always_comb begin
    w_keep = '1;
    if (w_first) w_keep = w_keep & r_keep_first;
    if (w_last)  w_keep = w_keep & r_keep_last;
  end
  assign dout_tkeep = w_keep;

  assign cmd_ready     = (r_state == S_IDLE);
  assign cmd_done      = (r_state == S_DONE);
  assign axi_m_arvalid = (r_state == S_ADDR);
  assign axi_m_araddr  = r_araddr;
  assign axi_m_arlen   = 8'(r_beats - 9'd1);
  assign axi_m_arsize  = 3'(W);
  assign axi_m_arburst = BURST_INCR;
  assign axi_m_arid    = 4'(ID);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_INIT;
      S_INIT: w_next = (w_total != '0) ? S_CALC : S_DONE;
      S_CALC: w_next = S_ADDR;
      S_ADDR: if (axi_m_arready) w_next = S_INCR;
      S_INCR: w_next = (w_next_remain != '0) ? S_CALC : S_WAIT;
      // The final beat may already have gone by while the last AR was retiring.
      S_WAIT: if ((r_beat_cnt == r_total) || (w_fire && w_last)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_bytes      <= '0;
      r_araddr     <= '0;
      r_remain     <= '0;
      r_total      <= '0;
      r_beats      <= '0;
      r_keep_first <= '0;
      r_keep_last  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_addr  <= cmd_address;
          r_bytes <= cmd_bytes;
        end
        S_INIT: begin
          r_total      <= w_total;
          r_remain     <= w_total;
          r_araddr     <= {r_addr[ADDRESS_BITS-1:W], {W{1'b0}}};
          r_keep_first <= w_kf[B-1:0];
          r_keep_last  <= w_kl[B-1:0];
        end
        S_CALC: r_beats <= w_calc_beats;
        S_INCR: begin
          r_araddr <= w_next_araddr;
          r_remain <= w_next_remain;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                r_beat_cnt <= '0;
    else if (r_state == S_INIT)  r_beat_cnt <= '0;
    else if (w_fire)             r_beat_cnt <= r_beat_cnt + CW'(1);
  end

`ifdef RDMA_ERR_REPORT_EN
  logic r_err;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                  r_err <= 1'b0;
    else if (r_state == S_INIT)                    r_err <= 1'b0;
    else if (w_fire && (axi_m_rresp != RESP_OKAY)) r_err <= 1'b1;
  end
  assign cmd_error = r_err;

  logic w_unused;
  assign w_unused = ^{axi_m_rid, axi_m_rlast};
`else
  assign cmd_error = 1'b0;

  logic w_unused;
  assign w_unused = ^{axi_m_rid, axi_m_rlast, axi_m_rresp};
`endif

endmodule
